// File: rtl/console_writer_if.sv
// Byte-stream input handshake plus text-buffer write port and display/cursor status.
interface console_writer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_glyph;
    logic [7:0] top_row;
    logic [7:0] cursor_x;
    logic [7:0] cursor_y;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_x, wr_y, wr_glyph, top_row, cursor_x, cursor_y
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_x, wr_y, wr_glyph, top_row, cursor_x, cursor_y
    );
endinterface

// File: rtl/console_writer.sv
// Terminal-style writer for the 80x30 console buffer: decodes bytes, moves the cursor,
// and scrolls by rotating top_row and blanking only the newly exposed bottom line.
module console_writer #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    console_writer_if.slave  bus
);
    localparam int unsigned XW    = 7;
    localparam int unsigned YW    = 5;
    localparam int unsigned CW    = 12;
    localparam int unsigned CELLS = COLS * ROWS;

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        CLEAR_LINE
    } state_t;

    state_t          state;
    logic            rdy;
    logic            wr_en;
    logic [7:0]      wr_x;
    logic [7:0]      wr_y;
    logic [7:0]      wr_glyph;
    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [YW-1:0]   top;
    logic [YW-1:0]   clr_row;
    logic [XW-1:0]   clr_x;
    logic [YW-1:0]   clr_y;
    logic [CW-1:0]   cnt;

    logic            accept_c;
    logic            printable_c;
    logic            newline_c;
    logic [YW-1:0]   cur_phys_c;

    // Logical row to physical row through the circular top_row offset.
    function automatic logic [YW-1:0] phys(input logic [YW-1:0] t, input logic [YW-1:0] y);
        logic [5:0] s;
        s = 6'(t) + 6'(y);
        if (s >= 6'(ROWS))
            s = s - 6'(ROWS);
        return s[YW-1:0];
    endfunction

    assign accept_c    = bus.in_valid && rdy;
    assign printable_c = (bus.in_data >= 8'h20);
    assign cur_phys_c  = phys(top, cur_y);
    assign newline_c   = accept_c &&
                         ((bus.in_data == 8'h0A) ||
                          (printable_c && (cur_x == XW'(COLS - 1))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ALL;
            rdy      <= 1'b0;
            wr_en    <= 1'b0;
            wr_x     <= 8'd0;
            wr_y     <= 8'd0;
            wr_glyph <= BLANK;
            cur_x    <= '0;
            cur_y    <= '0;
            top      <= '0;
            clr_row  <= '0;
            clr_x    <= '0;
            clr_y    <= '0;
            cnt      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                CLEAR_ALL: begin
                    wr_en    <= 1'b1;
                    wr_x     <= 8'(clr_x);
                    wr_y     <= 8'(clr_y);
                    wr_glyph <= BLANK;
                    if (cnt == CW'(CELLS - 1)) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                        clr_x <= '0;
                        clr_y <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (clr_x == XW'(COLS - 1)) begin
                            clr_x <= '0;
                            clr_y <= clr_y + YW'(1);
                        end else begin
                            clr_x <= clr_x + XW'(1);
                        end
                    end
                end

                CLEAR_LINE: begin
                    wr_en    <= 1'b1;
                    wr_x     <= 8'(clr_x);
                    wr_y     <= 8'(clr_row);
                    wr_glyph <= BLANK;
                    if (clr_x == XW'(COLS - 1)) begin
                        clr_x <= '0;
                        top   <= (top == YW'(ROWS - 1)) ? '0 : top + YW'(1);
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end

                IDLE: begin
                    if (accept_c) begin
                        if (bus.in_data == 8'h0D || bus.in_data == 8'h0A) begin
                            cur_x <= '0;
                        end else if (bus.in_data == 8'h08) begin
                            if (cur_x != '0) begin
                                cur_x    <= cur_x - XW'(1);
                                wr_en    <= 1'b1;
                                wr_x     <= 8'(cur_x - XW'(1));
                                wr_y     <= 8'(cur_phys_c);
                                wr_glyph <= BLANK;
                            end
                        end else if (bus.in_data == 8'h0C) begin
                            // Cell 0 is issued right away so the clear lines up with acceptance.
                            top      <= '0;
                            cur_x    <= '0;
                            cur_y    <= '0;
                            state    <= CLEAR_ALL;
                            rdy      <= 1'b0;
                            wr_en    <= 1'b1;
                            wr_x     <= 8'd0;
                            wr_y     <= 8'd0;
                            wr_glyph <= BLANK;
                            cnt      <= CW'(1);
                            clr_x    <= XW'(1);
                            clr_y    <= '0;
                        end else if (printable_c) begin
                            wr_en    <= 1'b1;
                            wr_x     <= 8'(cur_x);
                            wr_y     <= 8'(cur_phys_c);
                            wr_glyph <= bus.in_data;
                            if (cur_x == XW'(COLS - 1))
                                cur_x <= '0;
                            else
                                cur_x <= cur_x + XW'(1);
                        end

                        // At the bottom, scroll instead of descending.
                        if (newline_c) begin
                            if (cur_y < YW'(ROWS - 1)) begin
                                cur_y <= cur_y + YW'(1);
                            end else begin
                                clr_row <= top;
                                clr_x   <= '0;
                                state   <= CLEAR_LINE;
                                rdy     <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state <= CLEAR_ALL;
                    rdy   <= 1'b0;
                    cnt   <= '0;
                    clr_x <= '0;
                    clr_y <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready = rdy;
    assign bus.wr_en    = wr_en;
    assign bus.wr_x     = wr_x;
    assign bus.wr_y     = wr_y;
    assign bus.wr_glyph = wr_glyph;
    assign bus.top_row  = 8'(top);
    assign bus.cursor_x = 8'(cur_x);
    assign bus.cursor_y = 8'(cur_y);
endmodule

// File: doc/console_writer.md
# console_writer

Terminal-style controller for the 80x30 text buffer read by the VGA console. It accepts a byte stream over a valid/ready handshake and interprets printable and control bytes. It maintains the cursor and drives the buffer's single write port. Scrolling uses a circular row offset (`top_row`) that the display path adds to its row index; only the new bottom line is rewritten, so the whole buffer is never copied.

## Interface
- `COLS`, 80, characters per row (640/8)
- `ROWS`, 30, character rows (480/16)
- `BLANK`, 8'h20, glyph written when clearing
- `clk` in 1: pixel clock; sole clock
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: `in_data` is valid
- `in_data` in 8: character or control byte
- `in_ready` out 1: byte is accepted on a rising edge with `in_valid && in_ready`
- `wr_en` out 1: buffer write strobe, one cell per cycle
- `wr_x` out 8: physical column, 0..COLS-1
- `wr_y` out 8: physical row, 0..ROWS-1
- `wr_glyph` out 8: glyph code to write
- `top_row` out 8: physical row currently displayed as logical row 0
- `cursor_x` out 8: logical cursor column
- `cursor_y` out 8: logical cursor row

## Operation
- States:
  - `CLEAR_ALL`
  - `IDLE`
  - `CLEAR_LINE`
- `in_ready = (state == IDLE)`. No byte is ever accepted outside `IDLE`.
- Physical row: `phys(y) = top_row + y`, minus `ROWS` if the sum is >= `ROWS`. Internal width is 6 bits. Outputs are zero-extended to 8 bits.
- Byte decode on acceptance, in `IDLE`:
  - `0x0D` CR: `cursor_x` ← 0. No write.
  - `0x0A` LF: `cursor_x` ← 0, then NEWLINE. No write.
  - `0x08` BS:
    - If `cursor_x > 0`: `cursor_x` ← `cursor_x - 1`, then write `BLANK` at (new `cursor_x`, `phys(cursor_y)`).
    - At column 0: no effect.
  - `0x0C` FF: `top_row`, `cursor_x`, `cursor_y` ← 0, then go to `CLEAR_ALL`.
  - Other bytes < `0x20`: consumed and ignored.
  - Bytes >= `0x20`: printable.
    - Write `in_data` at (`cursor_x`, `phys(cursor_y)`).
    - If `cursor_x == COLS-1`: `cursor_x` ← 0, then NEWLINE.
    - Otherwise `cursor_x` ← `cursor_x + 1`.
- NEWLINE:
  - If `cursor_y < ROWS-1`: `cursor_y` ← `cursor_y + 1`.
  - Otherwise: `cursor_y` stays at `ROWS-1`, latch `clr_row = top_row`, and enter `CLEAR_LINE`.
- `CLEAR_LINE`:
  - Writes `BLANK` at x = 0..COLS-1 on `clr_row`, one per cycle.
  - After the last write, `top_row` ← (`top_row + 1`) mod `ROWS`, then go to `IDLE`.
- `CLEAR_ALL`:
  - Writes `BLANK` to all `ROWS*COLS` cells in row-major order, physical row 0 first. The cell counter is 12 bits.
  - Then go to `IDLE`.
- Rows below the cursor are always blank: they were cleared by `CLEAR_ALL` and only reached by cursor descent or `CLEAR_LINE`. Descending therefore never needs a clear.

## Timing
- Reset values:
  - state = `CLEAR_ALL`, counters 0
  - `in_ready` = 0, `wr_en` = 0
  - `wr_x`, `wr_y` = 0; `wr_glyph` = `BLANK`
  - `top_row`, `cursor_x`, `cursor_y` = 0
- Reset asserted in any state, mid-clear included, aborts the operation at the next edge and restarts the full clear.
- All outputs are registered.
- Byte accepted at edge E (end of cycle N):
  - Resulting write appears with `wr_en`=1 in cycle N+1.
  - Cursor and `top_row` updates are visible in N+1.
- Back-to-back printable bytes: throughput is 1 byte/cycle. `in_ready` stays high.
- Scroll triggered by a byte accepted in cycle N:
  - Any character write occurs in N+1.
  - Clear writes x=0..79 occur in N+2..N+81.
  - `in_ready` is 0 during N+1..N+80 and 1 in N+81.
  - `top_row` advances in N+81, the same cycle as the last clear write.
- `CLEAR_ALL` after reset release in cycle R:
  - Writes occur in R+1..R+2400.
  - `in_ready` rises in R+2400.
  - FF triggers the same sequence, counted from its acceptance cycle.
- `wr_en` is 0 in every cycle not listed above.
- `in_data` is ignored when `in_ready`=0.

## Test plan
- Reset release:
  - 2400 consecutive `wr_en` pulses with `BLANK`: first (0,0), last (79,29).
  - `in_ready` 0 until cycle 2400.
- After init, send "AB":
  - Writes (0,0,0x41) and (1,0,0x42) in consecutive cycles.
  - `cursor_x`=2, `in_ready` constantly 1.
- Send 80 × `0x41` on row 29 (cursor at (0,29), `top_row`=0):
  - Last char written at (79,29).
  - Then 80 `BLANK` writes on physical row 0.
  - `top_row`=1, cursor (0,29), `in_ready` low exactly 80 cycles.
  - Next char is written at `wr_y`=0.
- CR/BS:
  - From cursor (5,3), BS → `BLANK` write at (4,3), `cursor_x`=4.
  - CR → `cursor_x`=0, no write.
  - BS at column 0 → no write, cursor unchanged.
- Ignored and FF:
  - Byte `0x01` → accepted, no write, cursor unchanged.
  - Byte `0x0C` with `top_row`=7 → `top_row`=0, cursor (0,0), 2400-cycle clear, `in_ready` low meanwhile.
- Reset at cycle 40 of a `CLEAR_LINE`:
  - Next cycle `wr_en`=0 and all outputs are at reset values.
  - Full clear then restarts at (0,0).
